// File: rtl/miner_csr_pkg.sv
// miner_csr_pkg: register map, control/IRQ bit positions and ID default for the miner CSR block.
package miner_csr_pkg;
    localparam logic [4:0] ADDR_HEADER0  = 5'h00;
    localparam logic [4:0] ADDR_DIFF0    = 5'h08;
    localparam logic [4:0] ADDR_NONCE_LO = 5'h10;
    localparam logic [4:0] ADDR_NONCE_HI = 5'h11;
    localparam logic [4:0] ADDR_CTRL     = 5'h12;
    localparam logic [4:0] ADDR_STATUS   = 5'h13;
    localparam logic [4:0] ADDR_SOL_LO   = 5'h14;
    localparam logic [4:0] ADDR_SOL_HI   = 5'h15;
    localparam logic [4:0] ADDR_IRQ      = 5'h16;
    localparam logic [4:0] ADDR_ID       = 5'h17;
    localparam logic [4:0] ADDR_BUSY_LO  = 5'h18;
    localparam logic [4:0] ADDR_BUSY_HI  = 5'h19;
    localparam logic [4:0] ADDR_RUN_LO   = 5'h1A;
    localparam logic [4:0] ADDR_RUN_HI   = 5'h1B;
    localparam int NUM_RW        = 19;
    localparam int CTRL_RUN      = 0;
    localparam int CTRL_TEST     = 1;
    localparam int CTRL_HALT     = 2;
    localparam int CTRL_PADL_LSB = 3;
    localparam int CTRL_PADF_LSB = 11;
    localparam int IRQ_PEND      = 0;
    localparam int IRQ_EN        = 1;
    localparam logic [31:0] ID_DEFAULT = 32'h5333_4D31;
endpackage

// File: rtl/miner_avalon_csr_if.sv
// miner_avalon_csr_if: Avalon-MM slave bus bundle between the HPS lightweight bridge and the miner CSR.
interface miner_avalon_csr_if;
    logic [4:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [3:0]  avs_byteenable;
    logic [31:0] avs_readdata;
    logic        avs_readdatavalid;
    modport master (output avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
                    input avs_readdata, avs_readdatavalid);
    modport slave (input avs_address, avs_read, avs_write, avs_writedata, avs_byteenable,
                   output avs_readdata, avs_readdatavalid);
endinterface

// File: rtl/csr_be_reg32.sv
// csr_be_reg32: 32-bit byte-enabled register with sync reset, per-bit clear and a writable-bit mask.
module csr_be_reg32 #(
    parameter logic [31:0] MASK = '1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wd_i,
    input  logic [31:0] clr_i,
    output logic [31:0] q_o
);
    logic [31:0] q_q, q_d, bit_we;
    always_comb begin
        bit_we = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}} & {32{we_i}};
        q_d    = ((q_q & ~bit_we) | (wd_i & bit_we)) & ~clr_i & MASK;
    end
    always_ff @(posedge clk) q_q <= rst ? '0 : q_d;
    assign q_o = q_q;
endmodule

// File: rtl/miner_avalon_csr.sv
// miner_avalon_csr: Avalon-MM register bank driving sha3_256_miner, with solution snapshot and IRQ mask/ack.
// Defining MINER_CSR_PERF_EN adds 64-bit busy/run cycle counters at 0x18-0x1B.
module miner_avalon_csr
    import miner_csr_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = ID_DEFAULT,
    parameter int          CTRL_W   = 19
) (
    input  logic                clk,
    input  logic                rst,
    miner_avalon_csr_if.slave   avs,
    output logic [255:0]        header,
    output logic [255:0]        difficulty,
    output logic [63:0]         start_nonce,
    output logic [CTRL_W-1:0]   control,
    input  logic [63:0]         solution,
    input  logic [6:0]          status,
    input  logic                miner_irq,
    input  logic                miner_bsy,
    output logic                irq
);
    localparam logic [31:0] CTRL_MASK = 32'((64'd1 << CTRL_W) - 64'd1);
    logic [31:0] regs_q [NUM_RW];
    logic [31:0] readdata_q, rdata_d, sol_shadow_q;
    logic        readdatavalid_q, irq_en_q, ack;
    assign ack = avs.avs_write && avs.avs_address == ADDR_IRQ && avs.avs_byteenable[0] && avs.avs_writedata[IRQ_PEND];
    for (genvar g = 0; g < NUM_RW; g++) begin : g_rw
        csr_be_reg32 #(.MASK(g == int'(ADDR_CTRL) ? CTRL_MASK : '1)) u_reg (
            .clk  (clk),
            .rst  (rst),
            .we_i (avs.avs_write && avs.avs_address == 5'(g)),
            .be_i (avs.avs_byteenable),
            .wd_i (avs.avs_writedata),
            .clr_i(g == int'(ADDR_CTRL) ? {31'b0, ack} : 32'b0),
            .q_o  (regs_q[g])
        );
    end
    for (genvar g = 0; g < 8; g++) begin : g_pack
        assign header[32*g +: 32]     = regs_q[int'(ADDR_HEADER0) + g];
        assign difficulty[32*g +: 32] = regs_q[int'(ADDR_DIFF0) + g];
    end
    assign start_nonce = {regs_q[ADDR_NONCE_HI], regs_q[ADDR_NONCE_LO]};
    assign control     = regs_q[ADDR_CTRL][CTRL_W-1:0];
    assign irq         = miner_irq & irq_en_q;
`ifdef MINER_CSR_PERF_EN
    logic [63:0] busy_cnt_q, run_cnt_q;
    logic [31:0] busy_hi_q, run_hi_q;
    always_ff @(posedge clk) begin
        if (rst || (avs.avs_write && avs.avs_address == ADDR_BUSY_LO)) begin
            busy_cnt_q <= '0;
            run_cnt_q  <= '0;
        end else begin
            busy_cnt_q <= busy_cnt_q + 64'(miner_bsy);
            run_cnt_q  <= run_cnt_q + 64'(control[CTRL_RUN]);
        end
        if (rst) begin
            busy_hi_q <= '0;
            run_hi_q  <= '0;
        end else if (avs.avs_read) begin
            busy_hi_q <= avs.avs_address == ADDR_BUSY_LO ? busy_cnt_q[63:32] : busy_hi_q;
            run_hi_q  <= avs.avs_address == ADDR_RUN_LO ? run_cnt_q[63:32] : run_hi_q;
        end
    end
`endif
    // Read mux sees pre-write register values, so a read+write in one cycle returns old data.
    always_comb begin
        rdata_d = '0;
        case (avs.avs_address)
            ADDR_STATUS:  rdata_d = {24'b0, miner_bsy, status};
            ADDR_SOL_LO:  rdata_d = solution[31:0];
            ADDR_SOL_HI:  rdata_d = sol_shadow_q;
            ADDR_IRQ:     rdata_d = {30'b0, irq_en_q, miner_irq};
            ADDR_ID:      rdata_d = ID_VALUE;
`ifdef MINER_CSR_PERF_EN
            ADDR_BUSY_LO: rdata_d = busy_cnt_q[31:0];
            ADDR_BUSY_HI: rdata_d = busy_hi_q;
            ADDR_RUN_LO:  rdata_d = run_cnt_q[31:0];
            ADDR_RUN_HI:  rdata_d = run_hi_q;
`endif
            default:      rdata_d = avs.avs_address <= ADDR_CTRL ? regs_q[avs.avs_address] : '0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
            sol_shadow_q    <= '0;
            irq_en_q        <= 1'b0;
        end else begin
            readdatavalid_q <= avs.avs_read;
            if (avs.avs_read)
                readdata_q <= rdata_d;
            if (avs.avs_read && avs.avs_address == ADDR_SOL_LO)
                sol_shadow_q <= solution[63:32];
            if (avs.avs_write && avs.avs_address == ADDR_IRQ && avs.avs_byteenable[0])
                irq_en_q <= avs.avs_writedata[IRQ_EN];
        end
    end
    assign avs.avs_readdata      = readdata_q;
    assign avs.avs_readdatavalid = readdatavalid_q;
endmodule

// File: doc/miner_avalon_csr.md
Name: miner_avalon_csr

Overview:
- Avalon-MM slave register bank on the HPS lightweight bridge, directly upstream of sha3_256_miner.
- Holds header, difficulty, start_nonce and control words that drive the miner.
- Returns miner status and solution to software, with a coherent 64-bit snapshot.
- Masks and acknowledges the miner IRQ toward the HPS GIC.

Parameters:
- ID_VALUE, 32'h5333_4D31, constant returned by the ID register.
- CTRL_W, 19, width of miner control word; bits above CTRL_W-1 are write-ignored and read as 0.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high (already decided)
- avs_address  in  5  word address
- avs_read  in  1  read strobe
- avs_write  in  1  write strobe
- avs_writedata  in  32  write data
- avs_byteenable  in  4  byte lanes
- avs_readdata  out  32  registered read data
- avs_readdatavalid  out  1  read data valid, fixed latency 1
- header  out  256  to miner
- difficulty  out  256  to miner
- start_nonce  out  64  to miner
- control  out  CTRL_W  to miner: [18:11] padf, [10:3] padl, [2] halt, [1] test, [0] run
- solution  in  64  from miner
- status  in  7  from miner
- miner_irq  in  1  from miner
- miner_bsy  in  1  from miner
- irq  out  1  to HPS: miner_irq & irq_en

Behaviour:
- Register map (word address):
  - 0x00-0x07 HEADER: RW; word n = header[32n+31:32n].
  - 0x08-0x0F DIFF: RW; same word packing.
  - 0x10-0x11 NONCE: RW; lo, then hi.
  - 0x12 CTRL: RW.
  - 0x13 STATUS: RO; {24'b0, miner_bsy, status}.
  - 0x14 SOL_LO: RO; returns solution[31:0]; the same read loads sol_shadow <= solution[63:32].
  - 0x15 SOL_HI: RO; returns sol_shadow.
  - 0x16 IRQ: bit0 pending (RO, = miner_irq); bit1 irq_en (RW); write 1 to bit0 = ack.
  - 0x17 ID: RO, ID_VALUE.
  - 0x18-0x1F: reserved, read 0.
- Writes:
  - Single cycle, no waitrequest.
  - Each byte lane is updated only when its byteenable bit is 1.
  - Writes to RO or reserved addresses have no effect.
- Reads:
  - avs_readdata and avs_readdatavalid are registered and valid exactly 1 cycle after avs_read.
  - Back-to-back reads are allowed every cycle.
  - avs_readdata holds its last value when readdatavalid=0.
- avs_read and avs_write asserted in the same cycle: the write executes, the read returns data from before the write.
- IRQ ack (write with bit0=1 to 0x16):
  - Clears CTRL[0] (run) on the next edge; the miner then drops miner_irq within its own sync latency (3 cycles).
  - Bit1 in the same write updates irq_en normally.
  - Ack while miner_irq=0 still clears run.
- Reset (any cycle, including mid-transaction):
  - All RW registers, sol_shadow, avs_readdata, avs_readdatavalid and irq_en go to 0, so control=0 and irq=0.
  - A read accepted in the reset cycle produces no readdatavalid.
- irq is combinational AND of registered irq_en and miner_irq; no extra latency.
- Outputs to the miner change only on register writes; the miner resynchronises control itself.

Optional Feature:
- Macro MINER_CSR_PERF_EN.
- Defined: adds two 64-bit counters.
  - busy_cnt: increments each cycle miner_bsy=1.
  - run_cnt: increments each cycle control[0]=1.
  - Mapped at 0x18/0x19 (busy lo/hi) and 0x1A/0x1B (run lo/hi); lo reads snapshot hi as for SOL.
  - Both counters clear on rst and on any write to 0x18. They wrap at 2^64.
- Undefined: no counters; 0x18-0x1B read 0.

Decomposition:
- Package miner_csr_pkg: address localparams (ADDR_HEADER0 ... ADDR_ID), CTRL bit-position constants, ID_VALUE default, IRQ bit positions.
- One sub-module: csr_be_reg32, a 32-bit byte-enabled register with synchronous reset, instantiated per RW word.
- Read mux, snapshot and IRQ logic stay in the top module.

Test Plan:
- Reset, then read 0x17 -> readdatavalid one cycle later; data 32'h53334D31; all outputs 0.
- Write 0x00 = 32'hDEADBEEF with be=4'b0101, then read -> 32'h00AD00EF; header[31:0] = 32'h00AD00EF.
- Write 0x12 = 32'hFFFFFFFF -> control = 19'h7FFFF; read returns 32'h0007FFFF.
- Drive solution = 64'h1111_2222_3333_4444; read 0x14; change solution to 64'h5555...; read 0x15 -> 32'h33334444 then 32'h11112222.
- Write 0x16 = 2; raise miner_irq -> irq=1. Write 0x16 = 3 -> next cycle control[0]=0, irq_en stays 1. Write 0x16 = 0 with miner_irq=1 -> irq=0.
- Issue a read on the same cycle rst is asserted -> no readdatavalid; all registers read 0 afterward.
